// File: rtl/ir_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO; cur's address field can be driven onto sysbus.
// Optional sticky overflow flag and ovf port when IR_QUEUE_OVF_EN is defined.
module ir_queue #(
    parameter int                WORD_W  = 8,
    parameter int                OP_W    = 3,
    parameter int                DEPTH   = 4,
    parameter logic [OP_W-1:0]   LOAD_OP = 3'b000
) (
    input  logic                         clock,
    input  logic                         n_reset,
    inout  wire  [WORD_W-1:0]            sysbus,
    input  logic                         Addr_bus,
    input  logic                         push,
    input  logic                         push_ptr,
    input  logic                         advance,
    input  logic                         flush,
    output logic [OP_W-1:0]              op,
    output logic                         cur_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
`ifdef IR_QUEUE_OVF_EN
   ,output logic                         ovf
`endif
);
    localparam int AW = WORD_W - OP_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WORD_W-1:0] mem_q, mem_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic [WORD_W-1:0]            cur_q, cur_d;
    logic                         cur_valid_q, cur_valid_d;
`ifdef IR_QUEUE_OVF_EN
    logic                         ovf_q, ovf_d;
`endif

    logic [WORD_W-1:0] in_word;
    logic              do_push, is_empty, is_full;

    assign sysbus = Addr_bus ? {{OP_W{1'b0}}, cur_q[AW-1:0]} : {WORD_W{1'bz}};

    always_comb begin
        in_word     = push ? sysbus : {LOAD_OP, sysbus[AW-1:0]};
        do_push     = push | push_ptr;
        is_empty    = (count_q == '0);
        is_full     = (count_q == CW'(DEPTH));
        mem_d       = mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        cur_d       = cur_q;
        cur_valid_d = cur_valid_q;
`ifdef IR_QUEUE_OVF_EN
        ovf_d       = ovf_q;
`endif
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            cur_valid_d = 1'b0;
`ifdef IR_QUEUE_OVF_EN
            ovf_d       = 1'b0;
`endif
        end else if (advance) begin
            if (is_empty) begin
                // Bypass: a word arriving into an empty FIFO goes straight to cur.
                cur_valid_d = do_push;
                if (do_push) cur_d = in_word;
            end else begin
                cur_d       = mem_q[rd_ptr_q];
                cur_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + PW'(1);
                if (do_push) begin
                    mem_d[wr_ptr_q] = in_word;
                    wr_ptr_d        = wr_ptr_q + PW'(1);
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
        end else if (do_push) begin
            if (is_full) begin
`ifdef IR_QUEUE_OVF_EN
                ovf_d = 1'b1;
`endif
            end else begin
                mem_d[wr_ptr_q] = in_word;
                wr_ptr_d        = wr_ptr_q + PW'(1);
                count_d         = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            mem_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cur_q       <= '0;
            cur_valid_q <= 1'b0;
`ifdef IR_QUEUE_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            cur_q       <= cur_d;
            cur_valid_q <= cur_valid_d;
`ifdef IR_QUEUE_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign op        = cur_q[WORD_W-1 -: OP_W];
    assign cur_valid = cur_valid_q;
    assign count     = count_q;
    assign full      = is_full;
    assign empty     = is_empty;
`ifdef IR_QUEUE_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ir_queue.sv
// Scoreboard bench for ir_queue: stimulus queues expected cur words on each advance,
// a monitor pops and compares after the edge that applies the advance.
module tb_ir_queue;
    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    wire  [7:0] sysbus;
    logic [7:0] tb_bus = 8'h00;
    logic       tb_drive = 1'b0;
    logic       Addr_bus = 1'b0;
    logic       push = 1'b0, push_ptr = 1'b0, advance = 1'b0, flush = 1'b0;
    logic [2:0] op;
    logic       cur_valid, full, empty;
    logic [2:0] count;
`ifdef IR_QUEUE_OVF_EN
    logic       ovf;
`endif

    typedef struct { logic v; logic [7:0] w; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0;
    logic [7:0] wl [14] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76,
                            8'h87, 8'h98, 8'hA9, 8'hBA, 8'hCB, 8'hDC, 8'hED};

    assign sysbus = tb_drive ? tb_bus : 8'hzz;

    ir_queue dut (
        .clock(clock), .n_reset(n_reset), .sysbus(sysbus), .Addr_bus(Addr_bus),
        .push(push), .push_ptr(push_ptr), .advance(advance), .flush(flush),
        .op(op), .cur_valid(cur_valid), .count(count), .full(full), .empty(empty)
`ifdef IR_QUEUE_OVF_EN
       ,.ovf(ovf)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; an advance queues the cur contents expected afterwards.
    task automatic cyc(input logic p, input logic pp, input logic [7:0] d,
                       input logic adv, input logic fl, input logic ev, input logic [7:0] ew);
        push = p; push_ptr = pp; tb_bus = d; tb_drive = p | pp; Addr_bus = !(p | pp);
        advance = adv; flush = fl;
        if (adv && !fl) sb.push_back('{v: ev, w: ew});
        @(posedge clock); #1;
        push = 0; push_ptr = 0; tb_drive = 0; Addr_bus = 1; advance = 0; flush = 0;
    endtask

    task automatic chk_state(input string nm, input logic [2:0] c, input logic f,
                             input logic e, input logic cv);
        chk({nm, ".count"}, 8'(count), 8'(c));
        chk({nm, ".full"}, 8'(full), 8'(f));
        chk({nm, ".empty"}, 8'(empty), 8'(e));
        chk({nm, ".cur_valid"}, 8'(cur_valid), 8'(cv));
    endtask

    // Monitor
    initial begin
        logic adv_now;
        exp_t e;
        forever begin
            @(posedge clock);
            adv_now = advance && !flush && n_reset;
            @(negedge clock);
            if (adv_now) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL sb_underflow: got advance result, expected no entry");
                end else begin
                    e = sb.pop_front();
                    chk("mon.cur_valid", 8'(cur_valid), 8'(e.v));
                    chk("mon.op", 8'(op), 8'(e.w[7:5]));
                    if (Addr_bus && !tb_drive) chk("mon.addr", sysbus, {3'b000, e.w[4:0]});
                end
            end
        end
    end

    initial begin
        #12 n_reset = 1'b1;
        @(posedge clock); #1;
        Addr_bus = 1'b1;
        chk_state("reset", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("reset.op", 8'(op), 8'h00);
`ifdef IR_QUEUE_OVF_EN
        chk("reset.ovf", 8'(ovf), 8'h00);
`endif
        // In-order delivery
        cyc(1, 0, 8'h25, 0, 0, 0, 0);
        cyc(1, 0, 8'h47, 0, 0, 0, 0);
        cyc(1, 0, 8'hE1, 0, 0, 0, 0);
        chk_state("order.fill", 3'd3, 1'b0, 1'b0, 1'b0);
        cyc(0, 0, 0, 1, 0, 1, 8'h25);
        cyc(0, 0, 0, 1, 0, 1, 8'h47);
        cyc(0, 0, 0, 1, 0, 1, 8'hE1);
        chk_state("order.drain", 3'd0, 1'b0, 1'b1, 1'b1);
        cyc(0, 0, 0, 1, 0, 0, 8'hE1);  // advance on empty: cur kept, invalid
        // Pointer-indirect load
        cyc(0, 1, 8'hFA, 0, 0, 0, 0);
        chk("ptr.count", 8'(count), 8'h01);
        cyc(0, 0, 0, 1, 0, 1, 8'h1A);
        // Overflow
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 0, 8'(i), 0, 0, 0, 0);
            if (i == 4) chk_state("ovf.full4", 3'd4, 1'b1, 1'b0, 1'b1);
        end
        chk_state("ovf.drop", 3'd4, 1'b1, 1'b0, 1'b1);
`ifdef IR_QUEUE_OVF_EN
        chk("ovf.flag", 8'(ovf), 8'h01);
`endif
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 1, 0, 1, 8'(i));
        chk_state("ovf.drain", 3'd0, 1'b0, 1'b1, 1'b1);
        // Bypass on empty
        cyc(1, 0, 8'h33, 1, 0, 1, 8'h33);
        chk_state("bypass", 3'd0, 1'b0, 1'b1, 1'b1);
        // Full, push+advance for 10 cycles across pointer wrap
        for (int i = 0; i < 4; i++) cyc(1, 0, wl[i], 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, wl[i+4], 1, 0, 1, wl[i]);
            chk("wrap.count", 8'(count), 8'h04);
        end
        cyc(1, 0, 8'hFF, 0, 0, 0, 0);  // dropped
        chk("wrap.drop", 8'(count), 8'h04);
`ifdef IR_QUEUE_OVF_EN
        chk("wrap.ovf", 8'(ovf), 8'h01);
`endif
        cyc(0, 0, 0, 1, 0, 1, wl[10]);
        cyc(0, 0, 0, 1, 0, 1, wl[11]);
        chk("flush.pre", 8'(count), 8'h02);
        // Flush beats push
        cyc(1, 0, 8'h77, 0, 1, 0, 0);
        chk_state("flush", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("flush.op_kept", 8'(op), 8'(wl[11][7:5]));
`ifdef IR_QUEUE_OVF_EN
        chk("flush.ovf", 8'(ovf), 8'h00);
`endif
        cyc(0, 0, 0, 1, 0, 0, wl[11]);
        // Asynchronous reset mid-run
        cyc(1, 0, 8'h41, 0, 0, 0, 0);
        cyc(1, 0, 8'h62, 0, 0, 0, 0);
        cyc(1, 0, 8'h83, 0, 0, 0, 0);
        chk("midrst.pre", 8'(count), 8'h03);
        n_reset = 1'b0;
        #1;
        chk_state("midrst", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("midrst.op", 8'(op), 8'h00);
        #2 n_reset = 1'b1;
        @(posedge clock); #1;
        cyc(1, 0, 8'h5A, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 8'h5A);
        chk_state("post", 3'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clock); #1;
        chk("sb.left", 8'(sb.size()), 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
